// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end sharing one 2-bit ALU
// between two clients, with a registered, ID-tagged response.

module alu_rr_alu (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic [2:0] i_sel,
    output logic [1:0] o_result,
    output logic       o_carry,
    output logic       o_err
);

    logic [2:0] w_ext;

    // Bit 2 of the 3-bit intermediate is carry for ADD, borrow for SUB.
    always_comb begin
        w_ext = 3'b000;
        o_err = 1'b0;
        unique case (i_sel)
            3'b000:  w_ext = {1'b0, i_a} + {1'b0, i_b};
            3'b001:  w_ext = {1'b0, i_a} - {1'b0, i_b};
            3'b010:  w_ext = {1'b0, i_a & i_b};
            3'b011:  w_ext = {1'b0, i_a | i_b};
            3'b100:  w_ext = {1'b0, i_a ^ i_b};
            default: o_err = 1'b1;
        endcase
    end

    assign o_result = w_ext[1:0];
    assign o_carry  = w_ext[2];

endmodule

module alu_rr_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [1:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_ptr;
    logic [1:0] r_a;
    logic [1:0] r_b;
    logic [2:0] r_sel;
    logic       r_id;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [1:0] r_rsp_result;
    logic       r_rsp_carry;
    logic       r_rsp_err;
    logic [7:0] r_op_count;

    logic       w_idle;
    logic       w_gnt1;
    logic       w_take;
    logic [1:0] w_result;
    logic       w_carry;
    logic       w_err;

    // Readies are held low while reset is asserted, even in IDLE.
    assign w_idle = rst_n && (r_state == IDLE);
    assign w_gnt1 = req1_valid && (!req0_valid || r_ptr);
    assign w_take = w_idle && (req0_valid || req1_valid);

    assign req0_ready = w_idle && req0_valid && !w_gnt1;
    assign req1_ready = w_idle && w_gnt1;

    alu_rr_alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sel    (r_sel),
        .o_result (w_result),
        .o_carry  (w_carry),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= 1'b0;
            r_a          <= 2'b00;
            r_b          <= 2'b00;
            r_sel        <= 3'b000;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 2'b00;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_a     <= w_gnt1 ? req1_a : req0_a;
                        r_b     <= w_gnt1 ? req1_b : req0_b;
                        r_sel   <= w_gnt1 ? req1_sel : req0_sel;
                        r_id    <= w_gnt1;
                        r_ptr   <= !w_gnt1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= w_result;
                    r_rsp_carry  <= w_carry;
                    r_rsp_err    <= w_err;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed and randomized checks of
// alu_rr_scheduler against a transaction-level reference model.

module tb_alu_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [1:0] req0_a, req0_b;
    logic [2:0] req0_sel;
    logic       req1_valid, req1_ready;
    logic [1:0] req1_a, req1_b;
    logic [2:0] req1_sel;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [1:0] rsp_result;
    logic       rsp_carry, rsp_err;
    logic [7:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: one in-flight slot with an age in cycles.
    bit         m_busy;
    int         m_age;
    int         m_ptr;
    int         m_count;
    logic       m_id;
    logic [3:0] m_rsp;

    always #5 clk = ~clk;

    alu_rr_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Returns {err, carry, result[1:0]} from plain integer arithmetic.
    function automatic logic [3:0] ref_op(input int a, input int b,
                                          input int sel);
        int v;
        case (sel)
            0: v = a + b;
            1: v = (a - b + 8) % 8;
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            default: return 4'b1000;
        endcase
        return {1'b0, 1'(v / 4), 2'(v % 4)};
    endfunction

    task automatic m_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_ptr   = 0;
        m_count = 0;
        m_id    = 1'b0;
        m_rsp   = 4'h0;
    endtask

    task automatic chk_reset();
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_rsp_id", 8'(rsp_id), 8'd0);
        chk("rst_rsp_result", 8'(rsp_result), 8'd0);
        chk("rst_rsp_carry", 8'(rsp_carry), 8'd0);
        chk("rst_rsp_err", 8'(rsp_err), 8'd0);
        chk("rst_op_count", op_count, 8'd0);
        chk("rst_req0_ready", 8'(req0_ready), 8'd0);
        chk("rst_req1_ready", 8'(req1_ready), 8'd0);
    endtask

    // One clock cycle: check registered outputs, drive, check readies,
    // then advance the model across the coming rising edge.
    task automatic step(input int v0, input int a0, input int b0,
                        input int s0, input int v1, input int a1,
                        input int b1, input int s1, input int rr);
        bit e0, e1, showing;
        @(negedge clk);
        showing = m_busy && (m_age >= 2);
        chk("rsp_valid", 8'(rsp_valid), 8'(showing));
        if (showing) begin
            chk("rsp_id", 8'(rsp_id), 8'(m_id));
            chk("rsp_err_carry_res",
                8'({rsp_err, rsp_carry, rsp_result}), 8'(m_rsp));
        end
        chk("op_count", op_count, 8'(m_count));
        req0_valid = 1'(v0);
        req0_a     = 2'(a0);
        req0_b     = 2'(b0);
        req0_sel   = 3'(s0);
        req1_valid = 1'(v1);
        req1_a     = 2'(a1);
        req1_b     = 2'(b1);
        req1_sel   = 3'(s1);
        rsp_ready  = 1'(rr);
        #1;
        e0 = !m_busy && (v0 != 0) && !((v1 != 0) && m_ptr == 1);
        e1 = !m_busy && (v1 != 0) && !((v0 != 0) && m_ptr == 0);
        chk("req0_ready", 8'(req0_ready), 8'(e0));
        chk("req1_ready", 8'(req1_ready), 8'(e1));
        if (!m_busy) begin
            if (e0 || e1) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_id   = e1;
                m_rsp  = e1 ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
                m_ptr  = e1 ? 0 : 1;
            end
        end else if (m_age >= 2) begin
            if (rr != 0) begin
                m_busy  = 1'b0;
                m_count = (m_count + 1) % 256;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic idle(input int n, input int rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 2'd3;
        req0_b     = 2'd3;
        req0_sel   = 3'd0;
        req1_valid = 1'b1;
        req1_a     = 2'd3;
        req1_b     = 2'd3;
        req1_sel   = 3'd0;
        rsp_ready  = 1'b1;
        m_reset();
        #2;
        chk_reset();
        repeat (3) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;

        // ADD 3+1 from req0: result 00 carry 1
        step(1, 3, 1, 0, 0, 0, 0, 0, 1);
        idle(3, 1);
        // SUB 1-2 and 2-1 from req1
        step(0, 0, 0, 0, 1, 1, 2, 1, 1);
        idle(3, 1);
        step(0, 0, 0, 0, 1, 2, 1, 1, 1);
        idle(3, 1);

        // Both valid continuously: AND 3&2 vs XOR 3^1
        for (int i = 0; i < 18; i++) step(1, 3, 2, 2, 1, 3, 1, 4, 1);
        idle(3, 1);
        // Lone req1 right after a req1 grant
        step(0, 0, 0, 0, 1, 2, 3, 3, 1);
        idle(3, 1);
        step(0, 0, 0, 0, 1, 1, 3, 0, 1);
        idle(3, 1);

        // Response stall with both clients pushing
        step(1, 2, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 1, 1, 2, 2, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3, 1);

        // Invalid select
        step(1, 3, 3, 5, 0, 0, 0, 0, 1);
        idle(3, 1);

        // Reset asserted while the operation is in EXEC
        step(1, 2, 3, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1);

        // Enough back-to-back operations to wrap op_count
        for (int i = 0; i < 800; i++)
            step(1, i % 4, (i / 4) % 4, i % 6, 1, 3 - i % 4, i % 3,
                 (i + 2) % 8, 1);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 4000; i++)
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3) != 0));
        idle(4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Two-requester round-robin scheduler that shares one 2-bit ALU datapath (ADD/SUB/AND/OR/XOR) between two independent clients. Each client issues an operation over a valid/ready request channel. The scheduler latches the operands, executes on the shared ALU for one cycle and returns the registered result on a single valid/ready response channel tagged with the requester ID. It sits between the client logic and the ALU, which is instantiated inside this block.

## Interface
- No parameters; all widths fixed (2-bit operands, 3-bit op select).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a, req0_b  in  2 each  requester 0 operands.
- req0_sel  in  3  requester 0 op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101–111 invalid.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation (0/1).
- rsp_result  out  2  ALU result.
- rsp_carry  out  1  carry-out (ADD) / borrow (SUB); 0 otherwise.
- rsp_err  out  1  1 when the op select was invalid.
- op_count  out  8  completed transactions; wraps 255→0.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - EXEC: ALU evaluates the latched operands; the result is registered at the end of the cycle.
  - RESP: hold the response until accepted.
- IDLE transitions:
  - If any req*_valid is high, grant one requester, assert only that requester's ready (combinational), latch a/b/sel/id, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC → RESP unconditionally.
- RESP:
  - If rsp_ready is high, go to IDLE and increment op_count.
  - Otherwise hold; all rsp_* outputs stay stable.
- Arbitration is round-robin:
  - A 1-bit priority pointer names the favoured requester. It resets to requester 0.
  - If only one requester is valid, it wins regardless of the pointer.
  - If both are valid, the pointer's requester wins.
  - After any grant, the pointer moves to the other requester.
- req*_ready is 0 outside IDLE and 0 for the losing requester. No request is accepted while one is in flight.
- Arithmetic uses a 3-bit intermediate {carry,result}:
  - ADD = A+B.
  - SUB = A−B modulo 8, so carry=1 exactly when A<B.
  - Logic ops: carry=0.
- Invalid sel: result=00, carry=0, err=1. The transaction still completes and is counted.
- Reset values: FSM IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_result 00, rsp_carry 0, rsp_err 0, op_count 0, req*_ready 0.
- Reset assertion mid-transaction (EXEC or RESP) discards the in-flight operation. No response is produced and op_count is unchanged from reset value 0.

## Timing
- Cycle N: req valid&ready handshake; operands captured at the edge ending N.
- Cycle N+1: EXEC.
- Cycle N+2: rsp_valid=1 with final rsp_id/result/carry/err.
- Request-to-response latency is 2 cycles.
- If rsp_ready=1 in N+2, state is IDLE in N+3 and the next request can be accepted in N+3. Peak throughput is 1 operation per 3 cycles.
- rsp_valid falls in the cycle after the response handshake.
- op_count updates on the same edge that completes the response handshake.
- Request inputs are sampled only at the handshake; changes afterwards do not affect the in-flight operation.
- rsp_ready is ignored outside RESP.

## Test plan
- Reset, then req0 ADD A=3 B=1 with rsp_ready=1 → req0_ready high in cycle 0; rsp_valid in cycle 2 with id=0, result=00, carry=1, err=0; op_count=1.
- req1 SUB A=1 B=2 → response id=1, result=11, carry=1. Then req1 SUB A=2 B=1 → result=01, carry=0.
- Both valid continuously after reset with AND 3&2 / XOR 3^1 → grant order req0, req1, req0, …; results alternate 10 (id 0) and 10 (id 1). A lone req1 after a req1 grant is still granted immediately.
- rsp_ready held 0 for 5 cycles in RESP → rsp_* stable, both req*_ready stay 0, op_count unchanged. Releasing rsp_ready gives one increment.
- sel=101, A=3, B=3 → result=00, carry=0, err=1; op_count increments.
- rst_n pulsed low during EXEC → all outputs return to reset values asynchronously and no response is emitted. After 256 completed transactions, op_count reads 0.
